// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: bus request/hold, store lane steering, load extension.
// Optional alignment exception detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_access_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  op_q;
    logic [1:0]  off_q;
    logic        drop_q;
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        accept;
    logic [3:0]  wen_d;
    logic [31:0] wdata_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (req_op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load  = 1'b1;
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         is_store = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = req_addr[0];
            EXE_LW_OP, EXE_SW_OP:             misaligned = |req_addr[1:0];
            default: ;
        endcase
    end

    // Exceptions are raised only for the live request; a flushed instruction never faults.
    assign adel     = req_valid & is_load  & misaligned & ~flush;
    assign ades     = req_valid & is_store & misaligned & ~flush;
    assign badvaddr = (adel | ades) ? req_addr : 32'd0;
`else
    assign misaligned = 1'b0;
    assign adel       = 1'b0;
    assign ades       = 1'b0;
    assign badvaddr   = 32'd0;
`endif

    assign accept = (state == IDLE) & req_valid & (is_load | is_store) & ~flush & ~misaligned;
    assign stall  = accept | (state == BUSY);

    always_comb begin
        wen_d   = 4'b0000;
        wdata_d = 32'd0;
        case (req_op)
            EXE_SB_OP: begin
                wen_d   = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            EXE_SH_OP: begin
                wen_d   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            EXE_SW_OP: begin
                wen_d   = 4'b1111;
                wdata_d = req_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            EXE_LB_OP:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            EXE_LBU_OP: ext_data = {24'd0, rd_byte};
            EXE_LH_OP:  ext_data = {{16{rd_half[15]}}, rd_half};
            EXE_LHU_OP: ext_data = {16'd0, rd_half};
            EXE_LW_OP:  ext_data = mem_rdata;
            default:    ext_data = 32'd0;
        endcase
    end

    // NOTE: every register here is control/datapath state, so all take the async reset and use <=.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            op_q       <= 8'd0;
            off_q      <= 2'd0;
            drop_q     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            mem_en     <= 1'b0;
            mem_wen    <= 4'b0000;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (accept) begin
                        mem_en    <= 1'b1;
                        mem_wen   <= wen_d;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_d;
                        op_q      <= req_op;
                        off_q     <= req_addr[1:0];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) drop_q <= 1'b1;
                    if (mem_ack) begin
                        mem_en  <= 1'b0;
                        mem_wen <= 4'b0000;
                        // The bus transfer always completes; a flushed access just loses its response.
                        if (drop_q | flush) begin
                            state <= IDLE;
                        end else begin
                            resp_rdata <= ext_data;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequences MEM-stage load/store requests onto the single-ported data-memory bus. It generates word-aligned addresses, byte enables and lane-replicated write data, and holds the pipeline stalled for the variable-latency ack. It applies load byte/halfword selection and sign/zero extension before returning data to writeback. It sits between the MEM-stage pipeline registers and the data SRAM/bus bridge, and optionally flags address-alignment exceptions.

## Interface
Parameters: none. Op codes are the `EXE_*_OP` macros from `defines.vh`: LB, LBU, LH, LHU, LW, SB, SH, SW.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  MEM stage presents an access this cycle.
- req_op  in  8  alucontrol code of the access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- flush  in  1  exception/branch flush of the MEM-stage instruction.
- stall  out  1  hold MEM and earlier stages.
- resp_valid  out  1  one-cycle pulse; the access completed.
- resp_rdata  out  32  extended load data; 0 for stores.
- adel  out  1  load address error (macro-gated).
- ades  out  1  store address error (macro-gated).
- badvaddr  out  32  faulting address; valid while adel or ades is 1.
- mem_en  out  1  bus request.
- mem_wen  out  4  byte write enables; 0000 for loads.
- mem_addr  out  32  {req_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read data; valid when mem_ack is 1.

## Operation
- States: IDLE, BUSY, DONE. Reset drives IDLE and all outputs 0.
- IDLE, accept condition: req_valid & memory op & !flush & !misaligned.
  - On accept: register bus outputs, op and addr[1:0]; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_en = 1, with bus outputs held constant.
  - On mem_ack: capture the extended mem_rdata and go to DONE. If the drop flag is set, go to IDLE instead and emit no response.
- DONE: resp_valid = 1 for one cycle, then go to IDLE.
- stall = (IDLE & accept) | BUSY. stall is 0 in DONE.
- A non-memory req_op is ignored: no stall, no bus activity.
- Stores:
  - SB: wen = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wen = 0011 if addr[1]=0, 1100 if addr[1]=1; wdata = {2{wdata[15:0]}}.
  - SW: wen = 1111.
- Loads:
  - LB/LBU take byte lane addr[1:0], sign- or zero-extended to 24 upper bits.
  - LH/LHU take the halfword at addr[1], extended by 16 bits.
  - LW passes the word through.
- Flush during BUSY: the bus transaction is never abandoned. The drop flag is set, stall stays 1 until ack, the response is suppressed, and the drop flag is cleared in IDLE.
- Flush during DONE: resp_valid is still driven. The pipeline discards it.
- Reset mid-transaction: return to IDLE immediately. The bus bridge is reset by the same resetn.

## Timing
- Request accepted in cycle 0. mem_en rises in cycle 1.
- Ack may arrive in cycle 1 or later. resp_valid is asserted in the cycle after ack.
- Minimum access is 3 cycles, with stall = 1 in cycles 0 and 1.
- Each additional wait cycle of mem_ack adds one stall cycle.
- mem_en, mem_wen, mem_addr and mem_wdata are registered outputs and stay stable throughout BUSY.
- resp_rdata holds its value until the next capture.
- Back-to-back requests: a new request may be accepted in the cycle after DONE.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - A misaligned request is not issued and does not stall.
  - adel (loads) or ades (stores) is asserted combinationally in the request cycle, only when flush is 0. badvaddr = req_addr.
- Undefined:
  - adel and ades are tied to 0; badvaddr is tied to 0.
  - Nothing is treated as misaligned.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan
- LW at 0x100, ack in cycle 1, mem_rdata 0x8765_4321 → mem_addr 0x100, wen 0000; resp_valid in cycle 2 with resp_rdata 0x8765_4321; stall 1 for exactly 2 cycles.
- LB/LBU at 0x103 with mem_rdata 0x8000_0000 → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080. LH at 0x102 with mem_rdata 0x8001_1234 → 0xFFFF_8001.
- SB at 0x201 with data 0xAB; SH at 0x202 with data 0xBEEF → wen 0010 and wdata 0xABAB_ABAB; wen 1100 and wdata 0xBEEF_BEEF. mem_addr is 0x200 for both.
- mem_ack delayed 5 cycles → mem_en and outputs stable for 5 cycles; stall asserted for 6 cycles; resp_valid pulses once.
- flush asserted in BUSY, ack 2 cycles later → no resp_valid; FSM back in IDLE; the next LW is accepted normally.
- With `DMEM_ALIGN_CHECK_EN`: LW at 0x102 → adel = 1, badvaddr 0x102, no mem_en, stall 0. SH at 0x301 → ades = 1.
